// File: rtl/key_buffer_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | key_buffer_pkg : shared constants and sizing helper for key_buffer |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package key_buffer_pkg;

  localparam logic [7:0] EMPTY_CODE_DEFAULT = 8'h00;

  localparam logic [7:0] ASCII_BS  = 8'h08;
  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_ESC = 8'h1B;

  // Pointer width for a power-of-two DEPTH; never narrower than one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_buffer_sync_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | key_buffer_sync_fifo : power-of-two synchronous FIFO, comb. head  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module key_buffer_sync_fifo
  import key_buffer_pkg::*;
#(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 8,
  localparam int AW    = ptr_width(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/key_buffer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | key_buffer : queues translated key presses for the CPU data port  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module key_buffer
  import key_buffer_pkg::*;
#(
  parameter  int         DEPTH      = 8,
  parameter  logic [7:0] EMPTY_CODE = EMPTY_CODE_DEFAULT,
  localparam int         CW         = ptr_width(DEPTH) + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [7:0]    i_ascii_code,
  input  logic          i_key_press,
  input  logic          i_key_release,
  input  logic          i_data_rd,
  input  logic          i_flush,
  input  logic          i_ovf_clr,
  output logic [7:0]    o_data,
  output logic          o_ready,
  output logic [CW-1:0] o_count,
  output logic          o_overflow,
  output logic          o_key_held
);

  logic       rd_q;
  logic       rd_armed;
  logic       rd_fall;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_head;
  logic       drop;
  logic       overflow_q;
  logic       key_held_q;

  // Pop at the end of the access so the byte stays stable while the CPU reads.
  // rd_armed blocks a pop for a read that was already high at reset release.
  assign rd_fall = rd_armed && rd_q && !i_data_rd;
  assign drop    = i_key_press && fifo_full && !rd_fall;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_q       <= 1'b0;
      rd_armed   <= 1'b0;
      overflow_q <= 1'b0;
      key_held_q <= 1'b0;
    end else begin
      rd_q     <= i_data_rd;
      rd_armed <= rd_armed | ~i_data_rd;
      if (drop)           overflow_q <= 1'b1;
      else if (i_ovf_clr) overflow_q <= 1'b0;
      if (i_key_press)        key_held_q <= 1'b1;
      else if (i_key_release) key_held_q <= 1'b0;
    end
  end

  key_buffer_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .push    (i_key_press),
    .pop     (rd_fall),
    .flush   (i_flush),
    .wr_data (i_ascii_code),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (o_count)
  );

  assign o_data     = fifo_empty ? EMPTY_CODE : fifo_head;
  assign o_ready    = !fifo_empty;
  assign o_overflow = overflow_q;
  assign o_key_held = key_held_q;

endmodule
`default_nettype wire

// File: tb/tb_key_buffer.sv
`default_nettype none
// Self-checking bench for key_buffer: queue-based reference model, directed
// scenarios with literal pins, then randomized traffic.
module tb_key_buffer;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] code = 8'h00;
  logic       key_press = 1'b0;
  logic       key_release = 1'b0;
  logic       data_rd = 1'b0;
  logic       flush = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [7:0] o_data;
  logic       o_ready;
  logic [3:0] o_count;
  logic       o_overflow;
  logic       o_key_held;

  int vectors = 0;
  int miscompares = 0;

  key_buffer #(.DEPTH(DEPTH), .EMPTY_CODE(8'h00)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_ascii_code  (code),
    .i_key_press   (key_press),
    .i_key_release (key_release),
    .i_data_rd     (data_rd),
    .i_flush       (flush),
    .i_ovf_clr     (ovf_clr),
    .o_data        (o_data),
    .o_ready       (o_ready),
    .o_count       (o_count),
    .o_overflow    (o_overflow),
    .o_key_held    (o_key_held)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain byte queue plus a few flags.
  logic [7:0] mq[$];
  bit m_ovf = 0, m_held = 0, m_prev = 0, m_seen_low = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ovf = 0; m_held = 0; m_prev = 0; m_seen_low = 0;
    end else begin
      bit fall, drop;
      fall = m_seen_low && m_prev && !data_rd;
      drop = key_press && (mq.size() == DEPTH) && !fall;
      if (flush) mq.delete();
      else begin
        if (fall && mq.size() > 0) void'(mq.pop_front());
        if (key_press && mq.size() < DEPTH) mq.push_back(code);
      end
      if (drop) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
      if (key_press) m_held = 1;
      else if (key_release) m_held = 0;
      m_prev = data_rd;
      if (!data_rd) m_seen_low = 1;
    end
  end

  always @(negedge clk) begin
    logic [7:0] exp_data;
    exp_data = (mq.size() > 0) ? mq[0] : 8'h00;
    check("data", o_data, exp_data);
    check("ready", o_ready, mq.size() > 0);
    check("count", o_count, mq.size());
    check("overflow", o_overflow, m_ovf);
    check("key_held", o_key_held, m_held);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [7:0] c);
    code = c; key_press = 1'b1;
    cyc(1);
    key_press = 1'b0;
    cyc(1);
  endtask

  task automatic rd(input int n);
    data_rd = 1'b1;
    cyc(n);
    data_rd = 1'b0;
    cyc(1);
  endtask

  initial begin
    logic [7:0] seq [3];
    seq[0] = 8'h61; seq[1] = 8'h42; seq[2] = 8'h0D;

    cyc(3);
    check("rst_count", o_count, 0);
    check("rst_ready", o_ready, 0);
    check("rst_data", o_data, 8'h00);
    check("rst_ovf", o_overflow, 0);
    check("rst_held", o_key_held, 0);
    #2 rst_n = 1'b1;
    cyc(2);

    // Three presses, three reads in order.
    for (int i = 0; i < 3; i++) press(seq[i]);
    check("t1_count", o_count, 3);
    check("t1_ready", o_ready, 1);
    for (int i = 0; i < 3; i++) begin
      check("t1_head", o_data, seq[i]);
      rd(4);
    end
    check("t1_ready_end", o_ready, 0);
    check("t1_data_end", o_data, 8'h00);

    // Long read: head stable, single pop at the falling edge.
    press(8'h31);
    press(8'h32);
    data_rd = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      check("t2_stable", o_data, 8'h31);
    end
    data_rd = 1'b0;
    cyc(1);
    check("t2_count", o_count, 1);
    check("t2_next", o_data, 8'h32);
    rd(2);

    // Overflow: ninth byte dropped, then cleared.
    for (int i = 0; i < 9; i++) press(8'h30 + 8'(i));
    check("t3_count", o_count, 8);
    check("t3_ovf", o_overflow, 1);
    ovf_clr = 1'b1; cyc(1); ovf_clr = 1'b0; cyc(1);
    check("t3_ovf_clr", o_overflow, 0);

    // Full FIFO: push on the read falling edge is accepted.
    data_rd = 1'b1; cyc(2);
    data_rd = 1'b0; key_press = 1'b1; code = 8'h41;
    cyc(1);
    key_press = 1'b0;
    cyc(1);
    check("t4_count", o_count, 8);
    check("t4_ovf", o_overflow, 0);
    for (int i = 0; i < 8; i++) begin
      check("t4_drain", o_data, (i < 7) ? 8'h31 + 8'(i) : 8'h41);
      rd(4);
    end
    check("t4_empty", o_ready, 0);

    // Key-held behaviour.
    press(8'h1B);
    check("t5_held1", o_key_held, 1);
    code = 8'h1B; key_release = 1'b1; cyc(1); key_release = 1'b0; cyc(1);
    check("t5_held0", o_key_held, 0);
    check("t5_rel_count", o_count, 1);
    code = 8'h1B; key_press = 1'b1; key_release = 1'b1; cyc(1);
    key_press = 1'b0; key_release = 1'b0; cyc(1);
    check("t5_both", o_key_held, 1);
    check("t5_both_count", o_count, 2);
    flush = 1'b1; cyc(1); flush = 1'b0; cyc(1);
    check("t5_flush_count", o_count, 0);
    check("t5_flush_held", o_key_held, 1);

    // Reset in the middle of a read that spans reset release.
    press(8'h61); press(8'h62); press(8'h63);
    data_rd = 1'b1; cyc(2);
    #2 rst_n = 1'b0;
    cyc(2);
    #2 rst_n = 1'b1;
    cyc(3);
    check("t6_count_hi", o_count, 0);
    press(8'h64);
    data_rd = 1'b0; cyc(2);
    check("t6_count", o_count, 1);
    check("t6_data", o_data, 8'h64);
    rd(2);
    check("t6_empty_data", o_data, 8'h00);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      key_press   = ($urandom_range(0, 9) < 4);
      key_release = ($urandom_range(0, 9) == 0);
      code        = 8'($urandom);
      flush       = ($urandom_range(0, 49) == 0);
      ovf_clr     = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 3) == 0) data_rd = ~data_rd;
      cyc(1);
    end
    key_press = 0; key_release = 0; flush = 0; ovf_clr = 0; data_rd = 0;
    cyc(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/key_buffer.md
Name: key_buffer

Overview:
- Sits directly downstream of the PS/2-to-ASCII keyboard block and buffers its translated key presses for the CPU keyboard port.
- Each o_key_press/o_ascii_code event is queued in a small FIFO. The CPU read cycle consumes one byte per access.
- Also provides status flags (data ready, overflow) and a key-held level for software key-repeat and ESC handling.

Parameters:
DEPTH, 8, FIFO entries; must be a power of two, minimum 2.
EMPTY_CODE, 8'h00, value driven on o_data when the FIFO is empty.

Ports:
i_clk  input  1  system clock (10 MHz).
i_rst_n  input  1  asynchronous active-low reset.
i_ascii_code  input  8  ASCII code from keyboard block; valid when i_key_press or i_key_release is high.
i_key_press  input  1  one-cycle pulse: key pressed (includes typematic repeats).
i_key_release  input  1  one-cycle pulse: key released.
i_data_rd  input  1  CPU data-port read strobe, level, may stay high for several cycles.
i_flush  input  1  synchronous FIFO clear, one-cycle pulse.
i_ovf_clr  input  1  synchronous clear of the overflow flag, one-cycle pulse.
o_data  output  8  FIFO head byte, or EMPTY_CODE when empty.
o_ready  output  1  FIFO not empty.
o_count  output  $clog2(DEPTH)+1  number of stored entries.
o_overflow  output  1  sticky: a press was dropped because the FIFO was full.
o_key_held  output  1  the last keyboard event was a press.

Behaviour:
- Reset (async, i_rst_n low):
  - Read pointer, write pointer and count go to 0.
  - o_ready=0, o_overflow=0, o_key_held=0, o_data=EMPTY_CODE.
  - The registered copy of i_data_rd goes to 0.
  - Reset asserted mid-read discards all contents. No pop follows a read that spans reset release.
- Storage:
  - DEPTH x 8 memory addressed by pointers of width $clog2(DEPTH); pointers wrap modulo DEPTH.
  - o_count is held in a separate counter one bit wider than the pointers, so the full state is o_count==DEPTH.
- Push:
  - Occurs on a cycle with i_key_press=1. i_ascii_code is written at the write pointer, the pointer increments and the count increments.
  - Release events never push.
- Pop:
  - Occurs on the falling edge of i_data_rd (registered previous value 1, current value 0), i.e. at the end of the CPU read, so o_data stays stable for the whole access.
  - The read pointer increments and the count decrements.
  - A pop when empty is ignored; pointers and count are unchanged.
- o_data and o_ready:
  - o_data = mem[rd_ptr] when count!=0, else EMPTY_CODE. This is a combinational read of registered state.
  - A push into an empty FIFO is visible on o_data and o_ready the cycle after the push pulse (1-cycle latency).
  - o_ready = (count!=0).
- Simultaneous events:
  - Push and pop in the same cycle: both are performed and the count is unchanged. When empty, only the push takes effect.
  - Push when full with no pop in the same cycle: the byte is dropped, pointers and count are unchanged, and o_overflow is set to 1.
  - Push when full with a pop in the same cycle: the push is accepted and o_overflow is not set.
  - i_flush: pointers and count go to 0 next cycle. It overrides any push or pop in the same cycle. o_overflow is unaffected.
  - i_ovf_clr: o_overflow goes to 0. If an overflow drop occurs in the same cycle, set wins and o_overflow stays 1.
- o_key_held:
  - Set to 1 on i_key_press and cleared to 0 on i_key_release.
  - If both pulses arrive in the same cycle, press wins.
  - It is independent of FIFO state; flush does not clear it.
- No internal state machine beyond the FIFO control and the read-edge detector. All outputs other than o_data are registered.

Decomposition:
- Shared package holds:
  - the EMPTY_CODE default and the ASCII constants used by the keyboard path (CR 8'h0D, BS 8'h08, ESC 8'h1B);
  - a function for pointer width from DEPTH.
- One natural sub-module: sync_fifo.
  - Parameterised DEPTH/WIDTH; push, pop, flush, full, empty, count.
  - Instantiated by key_buffer, which adds the edge detector, the overflow and key-held logic, and the EMPTY_CODE mux.

Test Plan:
- Reset, then press 'a' (8'h61), 'B' (8'h42), CR (8'h0D) -> o_count=3, o_ready=1, o_data=8'h61. Three 4-cycle reads return 8'h61, 8'h42, 8'h0D in order, then o_ready=0 and o_data=8'h00.
- Hold i_data_rd high for 10 cycles with 8'h31 queued -> o_data=8'h31 throughout; exactly one pop, at the falling edge.
- Push 9 bytes (8'h30..8'h38) with DEPTH=8 -> o_count=8, o_overflow=1, 8'h38 is lost. Reads return 8'h30..8'h37. An i_ovf_clr pulse clears o_overflow.
- FIFO full, then a push pulse in the same cycle as the read falling edge -> push accepted, o_count stays 8, o_overflow=0. Then drain 8 entries and verify wrap-around order.
- Press then release ESC (8'h1B) -> o_key_held 1 then 0. Press and release in the same cycle -> o_key_held=1. A release alone never changes o_count.
- Assert i_rst_n low mid-read with 3 entries queued, then release it while i_data_rd is still high -> o_count=0. No pop or underflow occurs when i_data_rd later falls, and o_data=8'h00.
